// File: rtl/piso_serial_tx_if.sv
// Parallel word handshake into piso_serial_tx: upstream drives din/din_valid,
// the transmitter answers with din_ready.
interface piso_serial_tx_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (
      output din,
      output din_valid,
      input  din_ready
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready
   );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: MSB first, one bit per clock, framed by sframe.
// Define PISO_PARITY_EN to append an even-parity bit after bit 0.
module piso_serial_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   piso_serial_tx_if.slave   in_if,
   output logic              sdo,
   output logic              sframe,
   output logic              busy,
   output logic              done
);

`ifdef PISO_PARITY_EN
   localparam int unsigned NumBits = WIDTH + 1;
`else
   localparam int unsigned NumBits = WIDTH;
`endif
   // The first bit goes straight to sdo on accept, so only the rest is held.
   localparam int unsigned ShW     = NumBits - 1;
   localparam int unsigned CntW    = $clog2(NumBits);
   localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(NumBits - 1);
   localparam logic [GapW-1:0] LastGap = GapW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e          state_q, state_d;
   logic [ShW-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic            sdo_q, sdo_d;
   logic            sframe_q, sframe_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;
   logic [ShW-1:0]  load_val;

`ifdef PISO_PARITY_EN
   assign load_val = {in_if.din[WIDTH-2:0], ^in_if.din};
`else
   assign load_val = in_if.din[WIDTH-2:0];
`endif

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      sdo_d    = 1'b0;
      sframe_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ready_d  = ready_q;
      unique case (state_q)
         StIdle: begin
            if (in_if.din_valid && ready_q) begin
               state_d  = StShift;
               shreg_d  = load_val;
               cnt_d    = '0;
               sdo_d    = in_if.din[WIDTH-1];
               sframe_d = 1'b1;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
            end
         end
         StShift: begin
            if (cnt_q == LastBit) begin
               cnt_d  = '0;
               done_d = 1'b1;
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  state_d = StGap;
                  gap_d   = '0;
               end
            end else begin
               cnt_d    = cnt_q + CntW'(1);
               sdo_d    = shreg_q[ShW-1];
               sframe_d = 1'b1;
               shreg_d  = shreg_q << 1;
            end
         end
         StGap: begin
            if (gap_q == LastGap) begin
               state_d = StIdle;
               gap_d   = '0;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         sdo_q    <= 1'b0;
         sframe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         sdo_q    <= sdo_d;
         sframe_q <= sframe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign sdo             = sdo_q;
   assign sframe          = sframe_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign in_if.din_ready = ready_q;

endmodule
